// File: rtl/face_render_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : face_render_scheduler_pkg
// Description : Shared types, feature indices and width helpers for the
//               face render scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package face_render_scheduler_pkg;

    // Top-level sequencing states of the scheduler
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        START = 3'd2,
        DRAW  = 3'd3,
        SWAP  = 3'd4
    } render_state_t;

    // Feature draw order: lower indices are drawn first and get overwritten
    localparam int MOUTH_IDX = 0;
    localparam int EYES_IDX  = 1;
    localparam int BROWS_IDX = 2;

    // One colour channel of LOG_POWER_MOD bits for each of R, G and B
    function automatic int pixel_size(input int log_power_mod);
        return 3 * log_power_mod;
    endfunction

    // Address width of one frame-buffer bank
    function automatic int address_size(input int rows, input int pixels);
        return $clog2(rows * pixels);
    endfunction

    // Width of a feature index, never narrower than one bit
    function automatic int index_size(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/face_render_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : face_render_scheduler_if
// Description : Face-parameter input, feature-constructor handshake and
//               frame-buffer write port of the face render scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface face_render_scheduler_if #(
    parameter int NUM_FEATURES   = 3,
    parameter int NUM_BLOCK_ROWS = 16,
    parameter int NUM_PIXELS     = 128,
    parameter int FACE_RES       = 1 << 16,
    parameter int LOG_POWER_MOD  = 4
);
    import face_render_scheduler_pkg::*;

    localparam int LOG_FACE_RES = $clog2(FACE_RES);
    localparam int PIXEL_SIZE   = pixel_size(LOG_POWER_MOD);
    localparam int ADDRESS_SIZE = address_size(NUM_BLOCK_ROWS, NUM_PIXELS);

    logic                                         face_data_valid;
    logic [NUM_FEATURES-1:0][LOG_FACE_RES-1:0]    face_params;
    logic [NUM_FEATURES-1:0]                      feature_start;
    logic [NUM_FEATURES-1:0][LOG_FACE_RES-1:0]    feature_param;
    logic [NUM_FEATURES-1:0][ADDRESS_SIZE-1:0]    feature_pixel_address;
    logic [NUM_FEATURES-1:0][PIXEL_SIZE-1:0]      feature_pixel_data;
    logic [NUM_FEATURES-1:0]                      feature_pixel_valid;
    logic [ADDRESS_SIZE:0]                        fb_write_address;
    logic [PIXEL_SIZE-1:0]                        fb_write_data;
    logic                                         fb_write_enable;
    logic                                         display_bank;
    logic                                         frame_done;
    logic                                         busy;
    logic                                         timeout_error;

    // Scheduler side
    modport master (
        input  face_data_valid, face_params,
               feature_pixel_address, feature_pixel_data, feature_pixel_valid,
        output feature_start, feature_param,
               fb_write_address, fb_write_data, fb_write_enable,
               display_bank, frame_done, busy, timeout_error
    );

    // Environment side: parameter extraction, feature constructors, frame buffer
    modport slave (
        output face_data_valid, face_params,
               feature_pixel_address, feature_pixel_data, feature_pixel_valid,
        input  feature_start, feature_param,
               fb_write_address, fb_write_data, fb_write_enable,
               display_bank, frame_done, busy, timeout_error
    );

endinterface
`default_nettype wire

// File: rtl/face_render_scheduler_render_write_mux.sv
`default_nettype none
// ============================================================================
// Module      : face_render_scheduler_render_write_mux
// Description : Registered N:1 selection of the feature pixel streams with
//               zero-pixel suppression; one cycle from input to output.
// Revision    : 1.0 - initial release
// ============================================================================
module face_render_scheduler_render_write_mux #(
    parameter int NUM_FEATURES = 3,
    parameter int ADDRESS_SIZE = 11,
    parameter int PIXEL_SIZE   = 12,
    parameter int IDX_W        = 2
) (
    input  wire logic                                      clk_in,
    input  wire logic                                      rst_in,
    input  wire logic                                      capture_i,
    input  wire logic [IDX_W-1:0]                          sel_i,
    input  wire logic [NUM_FEATURES-1:0][ADDRESS_SIZE-1:0] pixel_address_i,
    input  wire logic [NUM_FEATURES-1:0][PIXEL_SIZE-1:0]   pixel_data_i,
    input  wire logic [NUM_FEATURES-1:0]                   pixel_valid_i,
    output logic                                           write_enable_o,
    output logic [ADDRESS_SIZE-1:0]                        write_address_o,
    output logic [PIXEL_SIZE-1:0]                          write_data_o,
    output logic                                           valid_o
);

    logic [ADDRESS_SIZE-1:0] sel_address;
    logic [PIXEL_SIZE-1:0]   sel_data;
    logic                    sel_valid;

    logic                    valid_q;
    logic                    we_q;
    logic [ADDRESS_SIZE-1:0] address_q;
    logic [PIXEL_SIZE-1:0]   data_q;

    // Pick the stream of the feature currently being drawn; others are ignored
    always_comb begin
        sel_address = '0;
        sel_data    = '0;
        sel_valid   = 1'b0;
        for (int k = 0; k < NUM_FEATURES; k++) begin
            if (sel_i == IDX_W'(k)) begin
                sel_address = pixel_address_i[k];
                sel_data    = pixel_data_i[k];
                sel_valid   = pixel_valid_i[k];
            end
        end
    end

    // Register the selected pixel; zero pixels never raise the write strobe
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
        end else begin
            valid_q   <= capture_i & sel_valid;
            we_q      <= capture_i & sel_valid & (sel_data != '0);
            address_q <= sel_address;
            data_q    <= sel_data;
        end
    end

    assign write_enable_o  = we_q;
    assign write_address_o = address_q;
    assign write_data_o    = data_q;
    assign valid_o         = valid_q;

endmodule
`default_nettype wire

// File: rtl/face_render_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : face_render_scheduler
// Description : Per face sample, clears the back bank, runs each feature
//               constructor in order onto the frame-buffer write port and
//               then swaps the displayed bank.
// Revision    : 1.0 - initial release
// ============================================================================
module face_render_scheduler #(
    parameter int NUM_FEATURES   = 3,
    parameter int NUM_BLOCK_ROWS = 16,
    parameter int NUM_PIXELS     = 128,
    parameter int FACE_RES       = 1 << 16,
    parameter int LOG_POWER_MOD  = 4,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  wire logic               clk_in,
    input  wire logic               rst_in,
    face_render_scheduler_if.master bus
);
    import face_render_scheduler_pkg::*;

    localparam int LOG_FACE_RES = $clog2(FACE_RES);
    localparam int PIXEL_SIZE   = pixel_size(LOG_POWER_MOD);
    localparam int ADDRESS_SIZE = address_size(NUM_BLOCK_ROWS, NUM_PIXELS);
    localparam int TOTAL        = NUM_BLOCK_ROWS * NUM_PIXELS;
    localparam int IDX_W        = index_size(NUM_FEATURES);
    localparam int WD_W         = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ADDRESS_SIZE:0] CLEAR_LAST = (ADDRESS_SIZE + 1)'(TOTAL - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_FEATURES - 1);
    localparam logic [WD_W-1:0]       WD_LIMIT   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]       WD_SAT     = WD_W'(TIMEOUT_CYCLES);

    render_state_t                             state_q, state_d;
    logic [IDX_W-1:0]                          idx_q, idx_d;
    logic [ADDRESS_SIZE:0]                     clr_cnt_q, clr_cnt_d;
    logic [WD_W-1:0]                           wd_q, wd_d;
    logic                                      seen_q, seen_d;
    logic                                      pending_q, pending_d;
    logic [NUM_FEATURES-1:0][LOG_FACE_RES-1:0] buffer_q, buffer_d;
    logic [NUM_FEATURES-1:0][LOG_FACE_RES-1:0] param_q, param_d;
    logic                                      display_bank_q, display_bank_d;
    logic                                      timeout_q, timeout_d;

    logic [NUM_FEATURES-1:0]                   start_c;
    logic                                      fb_we_c;
    logic [ADDRESS_SIZE:0]                     fb_addr_c;
    logic [PIXEL_SIZE-1:0]                     fb_data_c;
    logic                                      frame_done_c;
    logic                                      feature_done;

    logic                                      mux_we;
    logic [ADDRESS_SIZE-1:0]                   mux_addr;
    logic [PIXEL_SIZE-1:0]                     mux_data;
    logic                                      mux_valid;

    face_render_scheduler_render_write_mux #(
        .NUM_FEATURES (NUM_FEATURES),
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .PIXEL_SIZE   (PIXEL_SIZE),
        .IDX_W        (IDX_W)
    ) u_write_mux (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .capture_i       (state_q == DRAW),
        .sel_i           (idx_q),
        .pixel_address_i (bus.feature_pixel_address),
        .pixel_data_i    (bus.feature_pixel_data),
        .pixel_valid_i   (bus.feature_pixel_valid),
        .write_enable_o  (mux_we),
        .write_address_o (mux_addr),
        .write_data_o    (mux_data),
        .valid_o         (mux_valid)
    );

    // State and datapath registers; reset abandons any frame in progress
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            clr_cnt_q      <= '0;
            wd_q           <= '0;
            seen_q         <= 1'b0;
            pending_q      <= 1'b0;
            buffer_q       <= '0;
            param_q        <= '0;
            display_bank_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            clr_cnt_q      <= clr_cnt_d;
            wd_q           <= wd_d;
            seen_q         <= seen_d;
            pending_q      <= pending_d;
            buffer_q       <= buffer_d;
            param_q        <= param_d;
            display_bank_q <= display_bank_d;
            timeout_q      <= timeout_d;
        end
    end

    // Next-state logic and write-port steering
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        clr_cnt_d      = clr_cnt_q;
        wd_d           = wd_q;
        seen_d         = seen_q;
        pending_d      = pending_q;
        buffer_d       = buffer_q;
        param_d        = param_q;
        display_bank_d = display_bank_q;
        timeout_d      = timeout_q;
        start_c        = '0;
        fb_we_c        = 1'b0;
        fb_addr_c      = '0;
        fb_data_c      = '0;
        frame_done_c   = 1'b0;
        feature_done   = 1'b0;

        // A new sample is always accepted; it replaces any unconsumed one
        if (bus.face_data_valid) begin
            buffer_d  = bus.face_params;
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    param_d   = buffer_q;
                    clr_cnt_d = '0;
                    state_d   = CLEAR;
                    // A strobe in this cycle is a newer sample and stays pending
                    if (!bus.face_data_valid) begin
                        pending_d = 1'b0;
                    end
                end
            end

            CLEAR: begin
                fb_we_c   = 1'b1;
                fb_addr_c = {~display_bank_q, clr_cnt_q[ADDRESS_SIZE-1:0]};
                if (clr_cnt_q == CLEAR_LAST) begin
                    idx_d   = '0;
                    state_d = START;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            START: begin
                start_c = NUM_FEATURES'(1) << idx_q;
                seen_d  = 1'b0;
                wd_d    = '0;
                state_d = DRAW;
            end

            DRAW: begin
                fb_we_c   = mux_we;
                fb_addr_c = {~display_bank_q, mux_addr};
                fb_data_c = mux_data;
                if (mux_valid) begin
                    seen_d = 1'b1;
                end
                if (wd_q != WD_SAT) begin
                    wd_d = wd_q + 1'b1;
                end
                // Stream ends on the falling edge of valid; the watchdog
                // closes a feature that never starts or never stops
                if (seen_q && !mux_valid) begin
                    feature_done = 1'b1;
                end else if (wd_q == WD_LIMIT) begin
                    timeout_d    = 1'b1;
                    feature_done = 1'b1;
                end
                if (feature_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = SWAP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = START;
                    end
                end
            end

            SWAP: begin
                frame_done_c   = 1'b1;
                display_bank_d = ~display_bank_q;
                state_d        = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.feature_start    = start_c;
    assign bus.feature_param    = param_q;
    assign bus.fb_write_address = fb_addr_c;
    assign bus.fb_write_data    = fb_data_c;
    assign bus.fb_write_enable  = fb_we_c;
    assign bus.display_bank     = display_bank_q;
    assign bus.frame_done       = frame_done_c;
    assign bus.busy             = (state_q != IDLE);
    assign bus.timeout_error    = timeout_q;

endmodule
`default_nettype wire
